// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and encodings for the multi-cycle MIPS control FSM (ILLEGAL_TRAP_EN adds ST_TRAP)
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11,
`ifdef ILLEGAL_TRAP_EN
        ST_FAULT  = 4'd12,
        ST_TRAP   = 4'd13
`else
        ST_FAULT  = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

endpackage

// File: rtl/multicycle_aludec.sv
// rtl/multicycle_aludec.sv - ALU control decode from state-derived alu_op and funct
module multicycle_aludec
    import multicycle_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS control FSM with memory timeout and retired counter (ILLEGAL_TRAP_EN: unknown opcodes trap)
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             fault,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    // The counter only needs to reach TIMEOUT-1: the TIMEOUT-th idle cycle leaves the state.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    state_t            cur;
    state_t            nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              timed_out;
    logic [1:0]        alu_op;
    logic              alu_en;
    logic [2:0]        dec_ctrl;

    assign in_wait   = (cur == ST_FETCH) || (cur == ST_MEMRD) || (cur == ST_MEMWR);
    assign timed_out = (TIMEOUT > 0) && in_wait && !mem_ready && (wait_cnt == WAIT_LAST);
    assign state     = cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= ST_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            if (nxt != cur || TIMEOUT == 0) begin
                wait_cnt <= '0;
            end else if (in_wait && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (nxt == ST_FETCH && cur != ST_FETCH) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            ST_FETCH: begin
                if (mem_ready)      nxt = ST_DECODE;
                else if (timed_out) nxt = ST_FAULT;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = ST_MEMADR;
                    OP_RTYPE:     nxt = ST_EXEC;
                    OP_BEQ:       nxt = ST_BRANCH;
                    OP_ADDI:      nxt = ST_ADDIEX;
                    OP_J:         nxt = ST_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:      nxt = ST_TRAP;
`else
                    default:      nxt = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR: nxt = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD: begin
                if (mem_ready)      nxt = ST_MEMWB;
                else if (timed_out) nxt = ST_FAULT;
            end
            ST_MEMWR: begin
                if (mem_ready)      nxt = ST_FETCH;
                else if (timed_out) nxt = ST_FAULT;
            end
            ST_MEMWB:  nxt = ST_FETCH;
            ST_EXEC:   nxt = ST_ALUWB;
            ST_ALUWB:  nxt = ST_FETCH;
            ST_BRANCH: nxt = ST_FETCH;
            ST_ADDIEX: nxt = ST_ADDIWB;
            ST_ADDIWB: nxt = ST_FETCH;
            ST_JUMP:   nxt = ST_FETCH;
            ST_FAULT:  nxt = ST_FAULT;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:   nxt = ST_TRAP;
`endif
            default:   nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALUOP_ADD;
        alu_en     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        fault      = 1'b0;
        case (cur)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                alu_en    = 1'b1;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_BROFF;
                alu_en    = 1'b1;
            end
            ST_MEMADR, ST_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_en    = 1'b1;
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                alu_en    = 1'b1;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                alu_en    = 1'b1;
                pc_src    = PC_ALUOUT;
                pc_en     = zero;
            end
            ST_ADDIWB: reg_write = 1'b1;
            ST_JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
            end
            ST_FAULT: fault = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:  fault = 1'b1;
`endif
            default: ;
        endcase
        // No strobe may reach the datapath while reset is held, even in FETCH.
        if (!reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
        end
    end

    multicycle_aludec u_aludec (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (dec_ctrl)
    );

    assign alu_ctrl = alu_en ? dec_ctrl : ALU_AND;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller (honours ILLEGAL_TRAP_EN)
module tb_multicycle_controller;

    localparam int TO = 4;
    localparam int CW = 8;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIEX = 9,
                   P_ADDIWB = 10, P_JUMP = 11, P_FAULT = 12, P_TRAP = 13;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_read, mem_write, iord, ir_write, pc_en, alu_src_a;
    logic          reg_dst, mem_to_reg, reg_write, fault;
    logic [1:0]    pc_src, alu_src_b;
    logic [2:0]    alu_ctrl;
    logic [CW-1:0] retired;
    logic [3:0]    state;
    logic [16:0]   outs;

    int n_checks = 0;
    int n_pass   = 0;
    int ret_model = 0;

    multicycle_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .fault(fault),
        .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    assign outs = {mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                   alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, fault};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] funct_ctrl(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control word for one cycle of a phase, written straight from the per-state output list.
    function automatic logic [16:0] exp_out(input int ph, input logic rdy, input logic z, input logic [5:0] fn);
        logic mr = 0, mw = 0, io = 0, irw = 0, pe = 0, asa = 0, rd = 0, m2r = 0, rw = 0, flt = 0;
        logic [1:0] ps = 0, asb = 0;
        logic [2:0] ac = 0;
        case (ph)
            P_FETCH:  begin mr = 1; asb = 2'b01; ac = 3'b010; irw = rdy; pe = rdy; end
            P_DECODE: begin asb = 2'b11; ac = 3'b010; end
            P_MEMADR: begin asa = 1; asb = 2'b10; ac = 3'b010; end
            P_MEMRD:  begin mr = 1; io = 1; end
            P_MEMWB:  begin rw = 1; m2r = 1; end
            P_MEMWR:  begin mw = 1; io = 1; end
            P_EXEC:   begin asa = 1; ac = funct_ctrl(fn); end
            P_ALUWB:  begin rw = 1; rd = 1; end
            P_BRANCH: begin asa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
            P_ADDIEX: begin asa = 1; asb = 2'b10; ac = 3'b010; end
            P_ADDIWB: rw = 1;
            P_JUMP:   begin ps = 2'b10; pe = 1; end
            default:  flt = 1;
        endcase
        return {mr, mw, io, irw, pe, ps, asa, asb, ac, rd, m2r, rw, flt};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    task automatic step(input int ph, input logic rdy);
        mem_ready = rdy;
        #1;
        check_eq("state", state, ph);
        check_eq("ctl", outs, exp_out(ph, rdy, zero, funct));
        check_eq("retired", retired, ret_model);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("rst_state", state, P_FETCH);
        check_eq("rst_strobes", {mem_read, mem_write, ir_write, pc_en, reg_write}, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_retired", retired, 0);
        @(negedge clk);
        reset = 1'b1;
        ret_model = 0;
    endtask

    task automatic run_mem(input int ph, input int waits, output bit flt);
        for (int i = 0; i < waits && i < TO; i++) step(ph, 1'b0);
        if (waits >= TO) flt = 1;
        else begin
            step(ph, 1'b1);
            flt = 0;
        end
    endtask

    task automatic fault_seq();
        for (int i = 0; i < 3; i++) step(P_FAULT, rnd_bit());
        do_reset();
    endtask

    task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int wf, input int wm);
        bit flt;
        opcode = op;
        funct  = fn;
        zero   = z;
        run_mem(P_FETCH, wf, flt);
        if (flt) begin fault_seq(); return; end
        step(P_DECODE, rnd_bit());
        case (kind)
            K_LW: begin
                step(P_MEMADR, rnd_bit());
                run_mem(P_MEMRD, wm, flt);
                if (flt) begin fault_seq(); return; end
                step(P_MEMWB, rnd_bit());
            end
            K_SW: begin
                step(P_MEMADR, rnd_bit());
                run_mem(P_MEMWR, wm, flt);
                if (flt) begin fault_seq(); return; end
            end
            K_R:    begin step(P_EXEC, rnd_bit()); step(P_ALUWB, rnd_bit()); end
            K_BEQ:  step(P_BRANCH, rnd_bit());
            K_ADDI: begin step(P_ADDIEX, rnd_bit()); step(P_ADDIWB, rnd_bit()); end
            K_J:    step(P_JUMP, rnd_bit());
            default: begin
`ifdef ILLEGAL_TRAP_EN
                step(P_TRAP, rnd_bit());
                step(P_TRAP, rnd_bit());
                do_reset();
                return;
`endif
            end
        endcase
        ret_model = (ret_model + 1) % (1 << CW);
    endtask

    function automatic logic [5:0] kind_op(input int kind);
        logic [5:0] op;
        case (kind)
            K_LW:   return 6'b100011;
            K_SW:   return 6'b101011;
            K_R:    return 6'b000000;
            K_BEQ:  return 6'b000100;
            K_ADDI: return 6'b001000;
            K_J:    return 6'b000010;
            default: begin
                do op = 6'($urandom);
                while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
                return op;
            end
        endcase
    endfunction

    function automatic int rnd_wait();
        if ($urandom_range(0, 3) != 0) return 0;
        if ($urandom_range(0, 9) == 0) return TO;
        return $urandom_range(1, TO - 1);
    endfunction

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        do_reset();

        run_instr(K_LW, 6'b100011, 6'h00, 1'b0, 0, 0);
        run_instr(K_BEQ, 6'b000100, 6'h00, 1'b1, 0, 0);
        run_instr(K_BEQ, 6'b000100, 6'h00, 1'b0, 0, 0);
        run_instr(K_SW, 6'b101011, 6'h00, 1'b0, 0, 3);
        run_instr(K_R, 6'b000000, 6'b101010, 1'b0, 0, 0);
        run_instr(K_ADDI, 6'b001000, 6'h00, 1'b0, 1, 0);
        run_instr(K_J, 6'b000010, 6'h00, 1'b0, 0, 0);
        run_instr(K_ILL, 6'b111111, 6'h00, 1'b0, 0, 0);
        run_instr(K_J, 6'b000010, 6'h00, 1'b0, TO, 0);

        // Abort an lw in its writeback cycle.
        run_instr(K_J, 6'b000010, 6'h00, 1'b0, 0, 0);
        opcode = 6'b100011;
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b1);
        step(P_MEMADR, 1'b1);
        step(P_MEMRD, 1'b1);
        do_reset();

        for (int i = 0; i < 260; i++) run_instr(K_J, 6'b000010, 6'h00, 1'b0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 6);
            run_instr(k, kind_op(k), (k == K_R && $urandom_range(0, 1) == 1) ?
                      funct_sel($urandom_range(0, 4)) : 6'($urandom),
                      rnd_bit(), rnd_wait(), rnd_wait());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic [5:0] funct_sel(input int idx);
        case (idx)
            0: return 6'b100000;
            1: return 6'b100010;
            2: return 6'b100100;
            3: return 6'b100101;
            default: return 6'b101010;
        endcase
    endfunction

endmodule
